axi4_frame_reader: RTL and testbench
====================================

// Module: axi4_frame_reader
// PURPOSE
//  Parametrised AXI4 read master streaming one video frame per frame_start from a DDR frame buffer into an external dual-clock pixel FIFO.
//  Supports selectable frame buffers, multiple outstanding bursts and abort-and-restart mid-frame.
//  Sits between the PS DDR HP port and the display-side pixel FIFO / VTG.
// PARAMETERS
//  AXI_ADDR_WIDTH   32            address width
//  AXI_DATA_WIDTH   64            data width; DATA_BYTES = AXI_DATA_WIDTH/8
//  BURST_LEN        64            beats per burst (1..256); BURST_LEN*DATA_BYTES divides 4096
//  FRAME_BEATS      19200         beats per frame (320x240x16b / 64b); multiple of BURST_LEN
//  MAX_OUTSTANDING  2             max accepted-but-uncompleted ARs (1..4)
//  FIFO_DEPTH       1024          downstream FIFO capacity in beats
//  NUM_BUFS         3             frame buffers in DDR
//  FRAME_BASE_ADDR  32'h0100_0000 address of buffer 0; 4 KB aligned
//  FRAME_STRIDE     32'h0010_0000 byte distance between buffers; 4 KB aligned
// PORTS
//  clk_100Mhz     in   1   AXI / FIFO write clock
//  rst            in   1   reset, synchronous, active-high
//  frame_start    in   1   one-cycle pulse: begin new frame
//  buf_sel        in   2   buffer index, sampled on frame_start (< NUM_BUFS)
//  fifo_wr_count  in   11  downstream FIFO write-side occupancy (beats)
//  fifo_wr_en     out  1   FIFO write strobe
//  fifo_din       out  DW  FIFO write data (= RDATA)
//  frame_busy     out  1   high from frame_start until frame_done or abort complete
//  frame_done     out  1   one-cycle pulse, frame fully delivered
//  ARADDR ARVALID ARREADY ARLEN ARSIZE ARBURST ARCACHE   AXI4 AR channel
//  RDATA RVALID RREADY RLAST                              AXI4 R channel
// BEHAVIOUR
//  Constants: ARLEN=BURST_LEN-1, ARSIZE=log2(DATA_BYTES), ARBURST=INCR, ARCACHE=4'b1111.
//  Reset: ARVALID=0, RREADY=0, ARADDR=FRAME_BASE_ADDR, fifo_wr_en=0, frame_busy=0, frame_done=0; all counters 0, state IDLE.
//  FSM: IDLE -frame_start-> RUN (latch base=FRAME_BASE_ADDR+buf_sel*FRAME_STRIDE, burst_idx=0).
//       RUN  -last RLAST of frame accepted-> IDLE with frame_done pulse next cycle.
//       RUN  -frame_start-> DRAIN; DRAIN -outstanding==0 && !ARVALID-> RUN at new base.
//  AR issue: registered; ARVALID rises cycle after all hold: state RUN, !ARVALID, bursts_issued < FRAME_BEATS/BURST_LEN,
//    outstanding < MAX_OUTSTANDING, FIFO_DEPTH - fifo_wr_count - outstanding*BURST_LEN >= BURST_LEN.
//  ARADDR = base + burst_idx*BURST_LEN*DATA_BYTES; ARADDR stable while ARVALID; ARVALID held until ARREADY (also during DRAIN).
//  outstanding: +1 on AR handshake, -1 on RVALID&RREADY&RLAST; both same cycle -> unchanged.
//  RREADY=1 while outstanding>0 or ARVALID; credit check guarantees FIFO never overflows.
//  fifo_wr_en = RVALID & RREADY & (state==RUN); fifo_din = RDATA (combinational). Data ordered as issued.
//  DRAIN: R beats accepted and discarded (fifo_wr_en=0); no frame_done for aborted frame.
//  frame_start in DRAIN: re-latch buf_sel (last wins). frame_start on the cycle of final RLAST: frame_done still pulses, new frame starts.
//  rst mid-frame: immediate return to reset values; interconnect must be reset together.
// CONFIGURATION
//  AXI_RD_RESP_CHECK_EN defined: adds ports RRESP in 2, rresp_err_cnt out 16. Counter increments per accepted beat with RRESP[1]=1, saturates at 16'hFFFF, clears on frame_start and rst.
//  Undefined: ports absent, no response checking, data always forwarded.
// TESTING
//  1. rst held 3 cycles -> ARVALID=RREADY=fifo_wr_en=frame_done=frame_busy=0, ARADDR=32'h0100_0000.
//  2. frame_start, buf_sel=1, ARREADY=1, zero-wait slave, fifo_wr_count=0 -> 300 ARs at 32'h0110_0000+n*512, 19200 fifo_wr_en, one frame_done.
//  3. fifo_wr_count=961 -> no AR issued; drop to 960 -> ARVALID within 2 cycles.
//  4. slave 20-cycle R latency -> outstanding never >2, data order matches address order.
//  5. frame_start after 100 bursts with 2 outstanding, buf_sel=2 -> 128 beats discarded, next ARADDR=32'h0120_0000, no frame_done.
//  6. AXI_RD_RESP_CHECK_EN: RRESP=2'b10 on 5 beats -> rresp_err_cnt=5; cleared to 0 by next frame_start.

Source files
------------

// File: rtl/axi4_frame_reader.sv
// axi4_frame_reader: AXI4 read master that streams one frame per frame_start from a DDR buffer into a pixel FIFO.
// Optional feature macro AXI_RD_RESP_CHECK_EN adds RRESP input and a saturating rresp_err_cnt output.
module axi4_frame_reader #(
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter int                        AXI_DATA_WIDTH  = 64,
    parameter int                        BURST_LEN       = 64,
    parameter int                        FRAME_BEATS     = 19200,
    parameter int                        MAX_OUTSTANDING = 2,
    parameter int                        FIFO_DEPTH      = 1024,
    parameter int                        NUM_BUFS        = 3,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = 32'h0100_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE    = 32'h0010_0000
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [1:0]                buf_sel,
    input  logic [10:0]               fifo_wr_count,
    output logic                      fifo_wr_en,
    output logic [AXI_DATA_WIDTH-1:0] fifo_din,
    output logic                      frame_busy,
    output logic                      frame_done,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic                      RVALID,
    output logic                      RREADY,
`ifdef AXI_RD_RESP_CHECK_EN
    input  logic [1:0]                RRESP,
    output logic [15:0]               rresp_err_cnt,
`endif
    input  logic                      RLAST
);
    localparam int DATA_BYTES = AXI_DATA_WIDTH / 8;
    localparam int NUM_BURSTS = FRAME_BEATS / BURST_LEN;
    localparam int BW = $clog2(NUM_BURSTS + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * DATA_BYTES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] base;
    logic [AXI_ADDR_WIDTH-1:0] new_base;
    logic [BW-1:0]             burst_idx;
    logic [OW-1:0]             outstanding;
    logic [1:0]                sel;
    logic                      ar_fire;
    logic                      r_fire;
    logic                      last_fire;
    logic                      frame_end;
    logic                      credit;
    logic                      can_issue;

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = 3'($clog2(DATA_BYTES));
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'b1111;

    // Handshakes, end-of-frame detection and the AR issue gate; an out-of-range buffer index falls back to buffer 0
    always_comb begin
        ar_fire    = ARVALID & ARREADY;
        r_fire     = RVALID & RREADY;
        last_fire  = r_fire & RLAST;
        frame_end  = state == RUN && last_fire && int'(burst_idx) == NUM_BURSTS && !ARVALID && int'(outstanding) == 1;
        credit     = FIFO_DEPTH - int'(fifo_wr_count) - int'(outstanding) * BURST_LEN >= BURST_LEN;
        can_issue  = state == RUN && !frame_start && !ARVALID && int'(burst_idx) < NUM_BURSTS
                     && int'(outstanding) < MAX_OUTSTANDING && credit;
        sel        = int'(buf_sel) < NUM_BUFS ? buf_sel : 2'd0;
        new_base   = FRAME_BASE_ADDR + AXI_ADDR_WIDTH'(sel) * FRAME_STRIDE;
        RREADY     = outstanding != '0 || ARVALID;
        fifo_wr_en = r_fire && state == RUN;
        fifo_din   = RDATA;
    end

    // Frame FSM with registered AR channel, outstanding-burst tracking and frame status outputs
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state       <= IDLE;
            base        <= FRAME_BASE_ADDR;
            burst_idx   <= '0;
            outstanding <= '0;
            ARVALID     <= 1'b0;
            ARADDR      <= FRAME_BASE_ADDR;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            outstanding <= outstanding + OW'(ar_fire) - OW'(last_fire);
            frame_done  <= frame_end;
            if (can_issue) begin
                ARVALID   <= 1'b1;
                ARADDR    <= base + AXI_ADDR_WIDTH'(burst_idx) * BURST_BYTES;
                burst_idx <= burst_idx + BW'(1);
            end else if (ar_fire) begin
                ARVALID <= 1'b0;
            end
            if (frame_start) begin
                base       <= new_base;
                frame_busy <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state     <= RUN;
                        burst_idx <= '0;
                    end
                end
                RUN: begin
                    if (frame_start) begin
                        state     <= frame_end ? RUN : DRAIN;
                        burst_idx <= '0;
                    end else if (frame_end) begin
                        state      <= IDLE;
                        frame_busy <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0 && !ARVALID) begin
                        state     <= RUN;
                        burst_idx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_RD_RESP_CHECK_EN
    // Count error responses on accepted beats, saturating, cleared at every new frame
    always_ff @(posedge clk_100Mhz) begin
        if (rst || frame_start) rresp_err_cnt <= '0;
        else if (r_fire && RRESP[1] && rresp_err_cnt != 16'hFFFF) rresp_err_cnt <= rresp_err_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_axi4_frame_reader.sv
// tb_axi4_frame_reader: directed steps with a randomized AXI slave model and a frame-level reference checker.
module tb_axi4_frame_reader;
    localparam int FB = 19200;
    localparam int BL = 64;
    localparam logic [31:0] BASE0 = 32'h0100_0000;
    localparam logic [31:0] STRIDE = 32'h0010_0000;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [1:0]  buf_sel;
    logic [10:0] fifo_wr_count;
    logic        fifo_wr_en;
    logic [63:0] fifo_din;
    logic        frame_busy;
    logic        frame_done;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic [63:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [1:0]  rresp;
`ifdef AXI_RD_RESP_CHECK_EN
    logic [15:0] rresp_err_cnt;
`endif

    axi4_frame_reader dut (
        .clk_100Mhz(clk), .rst(rst), .frame_start(frame_start), .buf_sel(buf_sel),
        .fifo_wr_count(fifo_wr_count), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .frame_busy(frame_busy), .frame_done(frame_done),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARCACHE(ARCACHE),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
`ifdef AXI_RD_RESP_CHECK_EN
        .RRESP(rresp), .rresp_err_cnt(rresp_err_cnt),
`endif
        .RLAST(RLAST)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave/monitor state (written only by the slave process)
    logic [31:0] rq[$];
    int          rq_t[$];
    int          beat, outst, max_outst, cyc;
    bit          fire_ar, fire_r, rst_s, arv_pend;
    logic [31:0] ar_rec, arv_addr;
    logic [31:0] ar_log[$];
    int          arv_seen, stab_err, r_cnt, disc_cnt, wr_cnt, data_err, done_cnt, done_err, err_used;
    logic [31:0] exp_base;
    int          exp_idx;
    // Knobs (written only by the stimulus process)
    int          lat, gap_pct, err_req;
    bit          rand_ar;
    int          checks, errors;

    function automatic logic [63:0] dat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // AXI slave with configurable latency and gaps, plus frame-level reference checking of the FIFO stream
    initial begin
        RVALID = 0; RLAST = 0; RDATA = '0; ARREADY = 0; rresp = 2'b00;
        beat = 0; outst = 0; max_outst = 0; cyc = 0; fire_ar = 0; fire_r = 0; rst_s = 1; arv_pend = 0;
        ar_rec = '0; arv_addr = '0; arv_seen = 0; stab_err = 0; r_cnt = 0; disc_cnt = 0; wr_cnt = 0;
        data_err = 0; done_cnt = 0; done_err = 0; err_used = 0; exp_base = BASE0; exp_idx = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (fire_ar) begin
                rq.push_back(ar_rec);
                rq_t.push_back(cyc + lat);
                outst++;
            end
            if (fire_r) begin
                if (rresp[1]) err_used++;
                if (beat == BL - 1) begin
                    void'(rq.pop_front());
                    void'(rq_t.pop_front());
                    beat = 0;
                    outst--;
                end else beat++;
            end
            if (outst > max_outst) max_outst = outst;
            if (rst_s) begin
                rq.delete(); rq_t.delete(); beat = 0; outst = 0;
            end
            ARREADY = rand_ar ? ($urandom_range(0, 3) != 0) : 1'b1;
            RVALID = rq.size() != 0 && rq_t[0] <= cyc && int'($urandom_range(0, 99)) >= gap_pct;
            RLAST = RVALID && beat == BL - 1;
            RDATA = RVALID ? dat(rq[0] + 32'(beat * 8)) : '0;
            rresp = (RVALID && err_used < err_req) ? 2'b10 : 2'b00;
            #1;
            rst_s = rst;
            fire_ar = ARVALID && ARREADY;
            ar_rec = ARADDR;
            fire_r = RVALID && RREADY;
            if (fire_ar) ar_log.push_back(ARADDR);
            if (ARVALID) arv_seen++;
            if (arv_pend && (!ARVALID || ARADDR !== arv_addr)) stab_err++;
            arv_pend = ARVALID && !ARREADY && !rst;
            arv_addr = ARADDR;
            if (fire_r) begin
                r_cnt++;
                if (!fifo_wr_en) disc_cnt++;
            end
            if (fifo_wr_en) begin
                wr_cnt++;
                if (!fire_r || fifo_din !== dat(exp_base + 32'(exp_idx * 8))) data_err++;
                exp_idx++;
            end
            if (frame_done) begin
                done_cnt++;
                if (exp_idx != FB) done_err++;
            end
            if (frame_start) begin
                exp_base = BASE0 + 32'(buf_sel) * STRIDE;
                exp_idx = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [1:0] b);
        buf_sel = b;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done_cnt != d0), 64'd1);
    endtask

    function automatic int ar_bad(input int from, input int n, input logic [31:0] b);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (from + i >= ar_log.size() || ar_log[from + i] !== b + 32'(i * 512)) bad++;
        return bad;
    endfunction

    // Directed test sequence
    initial begin
        int s, a0, w0, d0, de0, dn0, st0, a_ab, w_ab, disc0, old_after, new_cnt, new_bad;
        checks = 0; errors = 0;
        rst = 1; frame_start = 0; buf_sel = 0; fifo_wr_count = 0;
        lat = 1; gap_pct = 0; rand_ar = 0; err_req = 0;
        repeat (3) @(negedge clk);
        check("rst_arvalid", 64'(ARVALID), 64'd0);
        check("rst_rready", 64'(RREADY), 64'd0);
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_busy", 64'(frame_busy), 64'd0);
        check("rst_araddr", 64'(ARADDR), 64'h0100_0000);
        check("arlen", 64'(ARLEN), 64'd63);
        check("arsize", 64'(ARSIZE), 64'd3);
        check("arburst", 64'(ARBURST), 64'd1);
        check("arcache", 64'(ARCACHE), 64'hF);
        rst = 0;
        @(negedge clk);

        // FIFO credit gating, then reset mid-frame
        fifo_wr_count = 961;
        start_frame(0);
        s = arv_seen;
        repeat (10) @(negedge clk);
        check("credit_busy", 64'(frame_busy), 64'd1);
        check("credit_blocked", 64'(arv_seen - s), 64'd0);
        a0 = ar_log.size();
        fifo_wr_count = 960;
        repeat (2) @(negedge clk);
        check("credit_release", 64'(arv_seen != s), 64'd1);
        check("credit_first_addr", 64'(ar_log.size() > a0 ? ar_log[a0] : 32'h0), 64'h0100_0000);
        rst = 1;
        fifo_wr_count = 0;
        repeat (2) @(negedge clk);
        check("midrst_busy", 64'(frame_busy), 64'd0);
        check("midrst_arvalid", 64'(ARVALID), 64'd0);
        check("midrst_araddr", 64'(ARADDR), 64'h0100_0000);
        rst = 0;
        repeat (2) @(negedge clk);

        // Full frame from buffer 1, zero-wait slave
        lat = 0;
        a0 = ar_log.size(); w0 = wr_cnt; d0 = done_cnt; de0 = data_err; dn0 = done_err; st0 = stab_err;
        err_req = err_used + 5;
        start_frame(1);
        wait_done("t2_done", 25000);
        repeat (5) @(negedge clk);
        check("t2_ar_count", 64'(ar_log.size() - a0), 64'd300);
        check("t2_ar_addr_bad", 64'(ar_bad(a0, 300, 32'h0110_0000)), 64'd0);
        check("t2_writes", 64'(wr_cnt - w0), 64'(FB));
        check("t2_data_err", 64'(data_err - de0), 64'd0);
        check("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t2_done_early", 64'(done_err - dn0), 64'd0);
        check("t2_busy_end", 64'(frame_busy), 64'd0);
`ifdef AXI_RD_RESP_CHECK_EN
        check("t6_rresp_cnt", 64'(rresp_err_cnt), 64'd5);
`endif

        // Latency 20, random R gaps and AR stalls, buffer 0
        lat = 20; gap_pct = 12; rand_ar = 1;
        a0 = ar_log.size(); w0 = wr_cnt; d0 = done_cnt; de0 = data_err;
        start_frame(0);
`ifdef AXI_RD_RESP_CHECK_EN
        check("t6_rresp_clear", 64'(rresp_err_cnt), 64'd0);
`endif
        wait_done("t4_done", 32000);
        repeat (5) @(negedge clk);
        check("t4_ar_addr_bad", 64'(ar_bad(a0, 300, 32'h0100_0000)), 64'd0);
        check("t4_ar_count", 64'(ar_log.size() - a0), 64'd300);
        check("t4_writes", 64'(wr_cnt - w0), 64'(FB));
        check("t4_data_err", 64'(data_err - de0), 64'd0);
        check("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t4_max_outstanding", 64'(max_outst), 64'd2);
        check("t4_ar_stability", 64'(stab_err - st0), 64'd0);

        // Abort after 100 bursts of buffer 1, restart on buffer 2
        lat = 20; gap_pct = 0; rand_ar = 0;
        a0 = ar_log.size(); w0 = wr_cnt; d0 = done_cnt; de0 = data_err; dn0 = done_err; disc0 = disc_cnt;
        start_frame(1);
        s = 0;
        while (ar_log.size() < a0 + 100 && s < 10000) begin
            @(negedge clk);
            s++;
        end
        check("t5_reach_100", 64'(ar_log.size() >= a0 + 100), 64'd1);
        start_frame(2);
        a_ab = ar_log.size(); w_ab = wr_cnt;
        wait_done("t5_done", 25000);
        repeat (5) @(negedge clk);
        old_after = 0; new_cnt = 0; new_bad = 0;
        for (int i = a_ab; i < ar_log.size(); i++) begin
            if (ar_log[i] < 32'h0120_0000) old_after++;
            else begin
                if (ar_log[i] !== 32'h0120_0000 + 32'(new_cnt * 512)) new_bad++;
                new_cnt++;
            end
        end
        check("t5_old_ar_after_abort", 64'(old_after <= 1), 64'd1);
        check("t5_new_ar_count", 64'(new_cnt), 64'd300);
        check("t5_new_ar_addr_bad", 64'(new_bad), 64'd0);
        check("t5_discarded", 64'(disc_cnt - disc0), 64'(BL * (a_ab - a0 + old_after) - (w_ab - w0)));
        check("t5_new_writes", 64'(wr_cnt - w_ab), 64'(FB));
        check("t5_data_err", 64'(data_err - de0), 64'd0);
        check("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t5_done_early", 64'(done_err - dn0), 64'd0);
        check("t5_busy_end", 64'(frame_busy), 64'd0);
        check("ar_stability_all", 64'(stab_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
